// File: rtl/energy_accumulator_if.sv
// energy_accumulator_if: partial-energy input stream and total-energy output stream of the accumulator
interface energy_accumulator_if #(
    parameter int ENERGY_TOTAL_BIT = 16,
    parameter int LOGSPIN          = 8
);
    logic                               partial_valid_i;
    logic                               partial_ready_o;
    logic signed [ENERGY_TOTAL_BIT-1:0] partial_energy_i;
    logic        [LOGSPIN-1:0]          spin_idx_o;
    logic                               energy_valid_o;
    logic                               energy_ready_i;
    logic signed [ENERGY_TOTAL_BIT-1:0] energy_o;
    logic                               overflow_o;

    modport master (
        output partial_valid_i, partial_energy_i, energy_ready_i,
        input  partial_ready_o, spin_idx_o, energy_valid_o, energy_o, overflow_o
    );

    modport slave (
        input  partial_valid_i, partial_energy_i, energy_ready_i,
        output partial_ready_o, spin_idx_o, energy_valid_o, energy_o, overflow_o
    );
endinterface

// File: rtl/energy_accumulator.sv
// energy_accumulator: sums DATASPIN signed partial energies into a saturated total; ENERGY_MIN_TRACK_EN adds running-minimum tracking
module energy_accumulator #(
    parameter int DATASPIN         = 256,
    parameter int ENERGY_TOTAL_BIT = 16,
    parameter int LOGSPIN          = $clog2(DATASPIN)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic clear_i,
    output logic busy_o,
`ifdef ENERGY_MIN_TRACK_EN
    output logic signed [ENERGY_TOTAL_BIT-1:0] min_energy_o,
    output logic                               new_min_o,
`endif
    energy_accumulator_if.slave bus
);
    localparam int W  = ENERGY_TOTAL_BIT;
    localparam int AW = W + LOGSPIN;
    localparam logic signed [AW-1:0] ACC_MAX = {{(LOGSPIN + 1){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = ~ACC_MAX;
    localparam logic signed [W-1:0] E_MAX = {1'b0, {(W - 1){1'b1}}};
    localparam logic signed [W-1:0] E_MIN = ~E_MAX;
    localparam logic [LOGSPIN-1:0] LAST = LOGSPIN'(DATASPIN - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                state_q, state_d;
    logic [LOGSPIN-1:0]    cnt_q, cnt_d;
    logic signed [AW-1:0]  acc_q, acc_d, sum;
    logic signed [W-1:0]   energy_q, energy_d, sat;
    logic                  ovf_q, ovf_d, hi, lo, hs, last_hs;

    // running sum including the current partial, and its clamp to the output range
    always_comb begin
        sum     = acc_q + {{LOGSPIN{bus.partial_energy_i[W-1]}}, bus.partial_energy_i};
        hi      = sum > ACC_MAX;
        lo      = sum < ACC_MIN;
        sat     = hi ? E_MAX : lo ? E_MIN : sum[W-1:0];
        hs      = state_q == ACCUM && bus.partial_valid_i;
        last_hs = hs && cnt_q == LAST;
    end

    // next-state: clear beats everything, start only from IDLE, total latched on the last handshake
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        energy_d = energy_q;
        ovf_d    = ovf_q;
        if (clear_i) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else if (state_q == IDLE && start_i) begin
            state_d = ACCUM;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (hs) begin
            acc_d = sum;
            cnt_d = last_hs ? '0 : cnt_q + LOGSPIN'(1);
            if (last_hs) begin
                state_d  = DONE;
                energy_d = sat;
                ovf_d    = hi | lo;
            end
        end else if (state_q == DONE && bus.energy_ready_i) begin
            state_d = IDLE;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            energy_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            energy_q <= energy_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.partial_ready_o = state_q == ACCUM;
    assign bus.energy_valid_o  = state_q == DONE;
    assign bus.spin_idx_o      = cnt_q;
    assign bus.energy_o        = energy_q;
    assign bus.overflow_o      = ovf_q;
    assign busy_o              = state_q != IDLE;

`ifdef ENERGY_MIN_TRACK_EN
    logic signed [W-1:0] min_q, min_d;
    logic                new_min_q, new_min_d;

    // lowest saturated total seen since reset; clear does not touch it
    always_comb begin
        min_d     = min_q;
        new_min_d = 1'b0;
        if (!clear_i && last_hs && sat < min_q) begin
            min_d     = sat;
            new_min_d = 1'b1;
        end
    end

    // minimum tracker registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            min_q     <= E_MAX;
            new_min_q <= 1'b0;
        end else begin
            min_q     <= min_d;
            new_min_q <= new_min_d;
        end
    end

    assign min_energy_o = min_q;
    assign new_min_o    = new_min_q;
`endif
endmodule

// File: tb/tb_energy_accumulator.sv
// tb_energy_accumulator: directed stimulus with a queue-based reference model checked every cycle
module tb_energy_accumulator;
    logic clk, rst, start, clear, busy;
`ifdef ENERGY_MIN_TRACK_EN
    logic signed [7:0] min_e;
    logic              new_min;
`endif
    int n_checks = 0;
    int n_fail   = 0;

    energy_accumulator_if #(.ENERGY_TOTAL_BIT(8), .LOGSPIN(2)) bus();

    energy_accumulator #(.DATASPIN(4), .ENERGY_TOTAL_BIT(8)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .clear_i(clear),
        .busy_o(busy),
`ifdef ENERGY_MIN_TRACK_EN
        .min_energy_o(min_e),
        .new_min_o(new_min),
`endif
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model: mode 0 idle, 1 collecting, 2 result held
    int m_mode, m_energy, m_ovf, m_min, m_newmin, m_sum;
    int m_q[$];

    initial begin
        m_mode = 0; m_energy = 0; m_ovf = 0; m_min = 127; m_newmin = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_mode = 0; m_q.delete(); m_energy = 0; m_ovf = 0; m_min = 127; m_newmin = 0;
            end else begin
                m_newmin = 0;
                if (clear) begin
                    m_mode = 0; m_q.delete(); m_ovf = 0;
                end else if (m_mode == 0 && start) begin
                    m_mode = 1; m_q.delete();
                end else if (m_mode == 1 && bus.partial_valid_i) begin
                    m_q.push_back(int'(bus.partial_energy_i));
                    if (m_q.size() == 4) begin
                        m_sum = 0;
                        foreach (m_q[i]) m_sum += m_q[i];
                        m_energy = m_sum > 127 ? 127 : m_sum < -128 ? -128 : m_sum;
                        m_ovf = m_sum != m_energy;
                        if (m_energy < m_min) begin
                            m_min = m_energy; m_newmin = 1;
                        end
                        m_mode = 2; m_q.delete();
                    end
                end else if (m_mode == 2 && bus.energy_ready_i) begin
                    m_mode = 0;
                end
            end
        end
    end

    // compare DUT against the model on every falling edge outside reset
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            chk("m_busy", busy, m_mode != 0);
            chk("m_ready", bus.partial_ready_o, m_mode == 1);
            chk("m_valid", bus.energy_valid_o, m_mode == 2);
            chk("m_spin_idx", bus.spin_idx_o, m_q.size());
            if (m_mode == 2) begin
                chk("m_energy", int'(bus.energy_o), m_energy);
                chk("m_overflow", bus.overflow_o, m_ovf);
            end
`ifdef ENERGY_MIN_TRACK_EN
            chk("m_min", int'(min_e), m_min);
            chk("m_new_min", new_min, m_newmin);
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int p0, p1, p2, p3, input int gap, input int hold,
                       input int exp_e, input int exp_o, input logic start_with_ready);
        int p[4];
        p = '{p0, p1, p2, p3};
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            repeat (gap) begin
                bus.partial_valid_i = 1'b0;
                step();
            end
            chk("spin_idx", bus.spin_idx_o, i);
            chk("no_early_valid", bus.energy_valid_o, 0);
            bus.partial_valid_i  = 1'b1;
            bus.partial_energy_i = 8'(p[i]);
            step();
        end
        bus.partial_valid_i = 1'b0;
        chk("valid_latency", bus.energy_valid_o, 1);
        chk("energy", int'(bus.energy_o), exp_e);
        chk("overflow", bus.overflow_o, exp_o);
        repeat (hold) begin
            step();
            chk("hold_valid", bus.energy_valid_o, 1);
            chk("hold_energy", int'(bus.energy_o), exp_e);
        end
        bus.energy_ready_i = 1'b1;
        start = start_with_ready;
        step();
        bus.energy_ready_i = 1'b0;
        start = 1'b0;
        chk("idle_after_ready", busy, 0);
        chk("valid_after_ready", bus.energy_valid_o, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; clear = 1'b0;
        bus.partial_valid_i = 1'b0; bus.partial_energy_i = '0; bus.energy_ready_i = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_ready", bus.partial_ready_o, 0);
        chk("rst_valid", bus.energy_valid_o, 0);
        chk("rst_energy", int'(bus.energy_o), 0);
        chk("rst_overflow", bus.overflow_o, 0);
        chk("rst_spin_idx", bus.spin_idx_o, 0);
        step();
        rst = 1'b0;
        bus.partial_valid_i = 1'b1; bus.partial_energy_i = 8'sd50;
        repeat (3) step();
        bus.partial_valid_i = 1'b0;
        chk("idle_ignores_partial", busy, 0);

        run(10, -3, 7, 1, 0, 0, 15, 0, 1'b0);
`ifdef ENERGY_MIN_TRACK_EN
        chk("min_after_15", int'(min_e), 15);
`endif
        run(5, 5, 5, 5, 0, 0, 20, 0, 1'b0);
`ifdef ENERGY_MIN_TRACK_EN
        chk("min_after_20", int'(min_e), 15);
`endif
        run(-5, 0, 0, 0, 0, 0, -5, 0, 1'b0);
`ifdef ENERGY_MIN_TRACK_EN
        chk("min_after_m5", int'(min_e), -5);
`endif
        run(100, 100, 100, -10, 0, 0, 127, 1, 1'b0);
        run(-128, -128, -128, -128, 0, 0, -128, 1, 1'b0);
        run(20, -7, 30, -3, 2, 5, 40, 0, 1'b0);
        run(3, 3, 3, 3, 0, 1, 12, 0, 1'b1);
        step();
        chk("start_with_ready_ignored", busy, 0);

        start = 1'b1;
        step();
        start = 1'b0;
        bus.partial_valid_i = 1'b1; bus.partial_energy_i = 8'sd9;
        repeat (2) step();
        bus.partial_valid_i = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear_busy", busy, 0);
        chk("clear_spin_idx", bus.spin_idx_o, 0);
        chk("clear_valid", bus.energy_valid_o, 0);
        chk("clear_overflow", bus.overflow_o, 0);
        run(1, 1, 1, 1, 0, 0, 4, 0, 1'b0);

        start = 1'b1;
        step();
        start = 1'b0;
        bus.partial_valid_i = 1'b1; bus.partial_energy_i = 8'sd20;
        repeat (2) step();
        #1;
        rst = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_ready", bus.partial_ready_o, 0);
        chk("async_spin_idx", bus.spin_idx_o, 0);
        chk("async_valid", bus.energy_valid_o, 0);
        chk("async_energy", int'(bus.energy_o), 0);
        chk("async_overflow", bus.overflow_o, 0);
`ifdef ENERGY_MIN_TRACK_EN
        chk("async_min", int'(min_e), 127);
`endif
        #1;
        rst = 1'b0;
        repeat (4) step();
        bus.partial_valid_i = 1'b0;
        chk("no_valid_after_reset", bus.energy_valid_o, 0);
        run(2, 2, 2, 2, 1, 0, 8, 0, 1'b0);
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/energy_accumulator.md
ENERGY_ACCUMULATOR -- requirements
Module: energy_accumulator

Interface
REQ-001 Parameter DATASPIN, default 256, meaning number of partial energies (one per spin) summed per total.
REQ-002 Parameter ENERGY_TOTAL_BIT, default 16, meaning signed width of each partial energy input and the total energy output.
REQ-003 Parameter LOGSPIN, default $clog2(DATASPIN), meaning spin index width.
REQ-004 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_i  input  1  asynchronous, active-high reset.
REQ-006 start_i  input  1  one-cycle request to begin a new accumulation.
REQ-007 clear_i  input  1  synchronous abort to IDLE.
REQ-008 partial_valid_i  input  1  upstream partial energy valid.
REQ-009 partial_ready_o  output  1  block accepts a partial energy.
REQ-010 partial_energy_i  input  ENERGY_TOTAL_BIT  signed partial energy of spin spin_idx_o.
REQ-011 spin_idx_o  output  LOGSPIN  index of the spin whose partial energy is expected next; drives upstream spin mask select.
REQ-012 energy_valid_o  output  1  total energy valid.
REQ-013 energy_ready_i  input  1  downstream accepts total energy.
REQ-014 energy_o  output  ENERGY_TOTAL_BIT  signed saturated total energy.
REQ-015 overflow_o  output  1  total was saturated; valid with energy_valid_o.
REQ-016 busy_o  output  1  high in ACCUM or DONE.

Function
REQ-017 FSM states SHALL be IDLE, ACCUM, DONE; reset state IDLE.
REQ-018 IDLE: partial_ready_o=0, energy_valid_o=0; start_i=1 -> ACCUM with counter=0 and accumulator=0.
REQ-019 ACCUM: partial_ready_o=1; each cycle with partial_valid_i=1 is a handshake that adds sign-extended partial_energy_i to accumulator and increments counter.
REQ-020 spin_idx_o SHALL equal the counter; counter wraps to 0 only via state exit, never within ACCUM.
REQ-021 Accumulator width SHALL be ENERGY_TOTAL_BIT+LOGSPIN, signed, so no internal overflow is possible.
REQ-022 Handshake with counter==DATASPIN-1 -> DONE; energy_o and overflow_o registered in the same edge; energy_valid_o high the following cycle (latency 1 cycle after last handshake).
REQ-023 energy_o SHALL be the full sum clamped to [-2^(ENERGY_TOTAL_BIT-1), 2^(ENERGY_TOTAL_BIT-1)-1]; overflow_o=1 iff clamping occurred.
REQ-024 Total SHALL be the plain sum of partials (no halving, no rescaling).
REQ-025 DONE: energy_valid_o=1, energy_o/overflow_o held stable until energy_ready_i=1; then -> IDLE next cycle.
REQ-026 start_i SHALL be ignored in ACCUM and DONE; start_i and energy_ready_i together in DONE -> IDLE (no back-to-back start).
REQ-027 clear_i SHALL have priority over all events: next state IDLE, counter=0, accumulator=0, energy_valid_o=0, overflow_o=0.
REQ-028 partial_valid_i outside ACCUM SHALL be ignored and have no effect.

Reset
REQ-029 rst_i=1 SHALL immediately force IDLE, counter=0, accumulator=0, energy_o=0, overflow_o=0, energy_valid_o=0, partial_ready_o=0, busy_o=0, spin_idx_o=0, independent of clk_i.
REQ-030 Reset asserted mid-ACCUM SHALL discard partial sum; no energy_valid_o pulse after release.

Configuration
REQ-031 Macro ENERGY_MIN_TRACK_EN defined: add outputs min_energy_o (ENERGY_TOTAL_BIT, signed) and new_min_o (1); min_energy_o resets to 2^(ENERGY_TOTAL_BIT-1)-1; on entry to DONE, if saturated total < min_energy_o, min_energy_o updates and new_min_o pulses for exactly one cycle; clear_i does not affect min_energy_o.
REQ-032 Macro undefined: min_energy_o and new_min_o ports and logic SHALL not exist; all other behaviour identical.

Verification (DATASPIN=4, ENERGY_TOTAL_BIT=8)
REQ-033 start, partials 10,-3,7,1 with valid always high -> spin_idx_o 0,1,2,3; energy_valid_o one cycle after 4th handshake; energy_o=15, overflow_o=0.
REQ-034 Partials 100,100,100,-10 -> energy_o=127, overflow_o=1; partials -128 x4 -> energy_o=-128, overflow_o=1.
REQ-035 Gapped partial_valid_i and energy_ready_i held low 5 cycles in DONE -> sum correct, energy_o stable all 5 cycles, IDLE one cycle after ready.
REQ-036 clear_i after 2 handshakes, then start with 1,1,1,1 -> energy_o=4, no earlier valid; rst_i pulse mid-ACCUM asynchronously -> all outputs 0 before next edge.
REQ-037 With ENERGY_MIN_TRACK_EN: totals 15 then 20 then -5 -> new_min_o pulses on first and third, min_energy_o=-5.
